muldiv_sequencer: RTL

//   Sequences the shared multi-cycle MULT/DIV units for the multicycle CPU main

---
 rtl/muldiv_sequencer_if.sv | 34 +++
 rtl/muldiv_sequencer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer_if.sv
// Handshake bundle between the multicycle CPU main control FSM and the
// MULT/DIV sequencer.
//   req, op, divisor_zero          : main control -> sequencer
//   busy                           : sequencer -> main control (stall)
//   mult_start, div_start          : sequencer start pulses to the units
//   himult_we, lomult_we           : HI/LO write enables, multiplier result
//   hidiv_we, lodiv_we             : HI/LO write enables, divider result
//   done, div0_exc                 : completion / divide-by-zero pulses
interface muldiv_sequencer_if;
    logic req;
    logic op;
    logic divisor_zero;
    logic busy;
    logic mult_start;
    logic div_start;
    logic himult_we;
    logic lomult_we;
    logic hidiv_we;
    logic lodiv_we;
    logic done;
    logic div0_exc;

    modport master (
        output req, op, divisor_zero,
        input  busy, mult_start, div_start, himult_we, lomult_we,
               hidiv_we, lodiv_we, done, div0_exc
    );

    modport slave (
        input  req, op, divisor_zero,
        output busy, mult_start, div_start, himult_we, lomult_we,
               hidiv_we, lodiv_we, done, div0_exc
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Sequences the shared multi-cycle MULT/DIV units for the main control FSM.
// One request is accepted in IDLE; the selected unit gets a one-cycle start
// pulse, the fixed unit latency is counted, then HI/LO write enables are
// issued and completion (or a divide-by-zero exception) is signalled.
// All outputs are Moore outputs decoded from the registered state/counter.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-high
//   bus    : muldiv_sequencer_if slave modport (req/op/divisor_zero in,
//            busy/start/write-enable/done/div0_exc out)
module muldiv_sequencer #(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    muldiv_sequencer_if.slave    bus
);

    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MULT_RUN  = 3'd1,
        DIV_CHECK = 3'd2,
        DIV_RUN   = 3'd3,
        WB        = 3'd4,
        DONE      = 3'd5,
        DIV0      = 3'd6
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             op_q, op_nxt;

    logic busy, mult_start, div_start;
    logic himult_we, lomult_we, hidiv_we, lodiv_we;
    logic done, div0_exc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            op_q  <= op_nxt;
        end
    end

    always_comb begin
        state_nxt  = IDLE;
        cnt_nxt    = cnt;
        op_nxt     = op_q;
        busy       = 1'b0;
        mult_start = 1'b0;
        div_start  = 1'b0;
        himult_we  = 1'b0;
        lomult_we  = 1'b0;
        hidiv_we   = 1'b0;
        lodiv_we   = 1'b0;
        done       = 1'b0;
        div0_exc   = 1'b0;

        case (state)
            IDLE: begin
                if (bus.req) begin
                    op_nxt    = bus.op;
                    cnt_nxt   = '0;
                    state_nxt = bus.op ? DIV_CHECK : MULT_RUN;
                end
            end
            MULT_RUN: begin
                busy       = 1'b1;
                mult_start = (cnt == '0);
                // Exit on the last count so the counter never wraps.
                if (cnt == MULT_LAST) begin
                    state_nxt = WB;
                end else begin
                    state_nxt = MULT_RUN;
                    cnt_nxt   = cnt + CNT_W'(1);
                end
            end
            DIV_CHECK: begin
                busy      = 1'b1;
                cnt_nxt   = '0;
                state_nxt = bus.divisor_zero ? DIV0 : DIV_RUN;
            end
            DIV_RUN: begin
                busy      = 1'b1;
                div_start = (cnt == '0);
                if (cnt == DIV_LAST) begin
                    state_nxt = WB;
                end else begin
                    state_nxt = DIV_RUN;
                    cnt_nxt   = cnt + CNT_W'(1);
                end
            end
            WB: begin
                busy      = 1'b1;
                himult_we = ~op_q;
                lomult_we = ~op_q;
                hidiv_we  = op_q;
                lodiv_we  = op_q;
                state_nxt = DONE;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            DIV0: begin
                busy     = 1'b1;
                div0_exc = 1'b1;
            end
            default: begin
                // Unused encoding: outputs stay 0, recover to IDLE.
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.busy       = busy;
    assign bus.mult_start = mult_start;
    assign bus.div_start  = div_start;
    assign bus.himult_we  = himult_we;
    assign bus.lomult_we  = lomult_we;
    assign bus.hidiv_we   = hidiv_we;
    assign bus.lodiv_we   = lodiv_we;
    assign bus.done       = done;
    assign bus.div0_exc   = div0_exc;

endmodule
